pwm_cmp_demux_8x1: RTL and testbench

//   Write side of the 8-channel PWM compare bank. Routes one 16-bit compare

---
 rtl/pwm_cmp_demux_8x1.sv | 98 +++++++++
 tb/tb_pwm_cmp_demux_8x1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmp_demux_8x1.sv
// PWM compare bank write side: routes writes to 8 double-buffered channels.
// Active values change on a period-boundary commit, or at once in bypass mode.
module pwm_cmp_demux_8x1 #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              upd_mode,
  input  logic              load_strobe,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [DATA_W-1:0] out_4,
  output logic [DATA_W-1:0] out_5,
  output logic [DATA_W-1:0] out_6,
  output logic [DATA_W-1:0] out_7,
  output logic [7:0]        pend,
  output logic              upd_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [7:0][DATA_W-1:0] shadow;
  logic [7:0][DATA_W-1:0] act;
  logic                   accept;
  logic                   shd_wr;

  assign wr_ready = (state == IDLE);
  assign upd_done = (state == COMMIT);
  assign accept   = wr_valid && wr_ready;
  assign shd_wr   = accept && !upd_mode;

  // Old pend is sampled, so a same-cycle shadowed write must be ORed in.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load_strobe && ((pend != 8'h00) || shd_wr))
          state_nxt = COMMIT;
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= RST_VAL;
        act[i]    <= RST_VAL;
      end
      pend <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i])
          act[i] <= shadow[i];
      end
      pend <= '0;
    end else if (accept) begin
      shadow[wr_sel] <= wr_data;
      if (upd_mode) begin
        act[wr_sel]  <= wr_data;
        pend[wr_sel] <= 1'b0;
      end else begin
        pend[wr_sel] <= 1'b1;
      end
    end
  end

  assign out_0 = act[0];
  assign out_1 = act[1];
  assign out_2 = act[2];
  assign out_3 = act[3];
  assign out_4 = act[4];
  assign out_5 = act[5];
  assign out_6 = act[6];
  assign out_7 = act[7];

endmodule

// File: tb/tb_pwm_cmp_demux_8x1.sv
// Bench for pwm_cmp_demux_8x1: per-cycle scoreboard fed by a
// behavioural model, directed scenarios then random traffic.
module tb_pwm_cmp_demux_8x1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic        upd_mode = 1'b0;
  logic        load_strobe = 1'b0;
  logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  pend;
  logic        upd_done;

  pwm_cmp_demux_8x1 #(.DATA_W(16), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data),
    .upd_mode(upd_mode), .load_strobe(load_strobe),
    .out_0(o0), .out_1(o1), .out_2(o2), .out_3(o3),
    .out_4(o4), .out_5(o5), .out_6(o6), .out_7(o7),
    .pend(pend), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0] o;
    logic [7:0]       p;
    logic             rdy;
    logic             ud;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_upd = 0;

  logic [15:0] m_act [8];
  logic [15:0] m_sh  [8];
  logic [7:0]  m_pend;
  bit          m_com;

  logic [7:0][15:0] outs;
  assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

  task automatic chk(input string nm, input int ch,
                     input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h",
               nm, ch, $time, got, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    for (int i = 0; i < 8; i++)
      chk("out", i, outs[i], e.o[i]);
    chk("pend", 0, {8'h00, pend}, {8'h00, e.p});
    chk("wr_ready", 0, {15'h0, wr_ready}, {15'h0, e.rdy});
    chk("upd_done", 0, {15'h0, upd_done}, {15'h0, e.ud});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = '0;
      m_sh[i]  = '0;
    end
    m_pend = '0;
    m_com  = 1'b0;
  endtask

  // Monitor: compares the DUT against the next expected snapshot.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0 && rstn) begin
        e = q.pop_front();
        chk_all(e);
        if (upd_done) n_upd++;
      end
    end
  end

  // Drive one cycle and predict the state after the coming edge.
  task automatic step(input logic v, input logic [2:0] s,
                      input logic [15:0] d, input logic m,
                      input logic st, output logic acc);
    exp_t e;
    bit   go;
    @(negedge clk);
    wr_valid    = v;
    wr_sel      = s;
    wr_data     = d;
    upd_mode    = m;
    load_strobe = st;
    acc = v && !m_com;
    if (m_com) begin
      for (int i = 0; i < 8; i++)
        if (m_pend[i]) m_act[i] = m_sh[i];
      m_pend = '0;
      m_com  = 1'b0;
    end else begin
      go = st && (m_pend != 0 || (acc && !m));
      if (acc) begin
        m_sh[s] = d;
        if (m) begin
          m_act[s]  = d;
          m_pend[s] = 1'b0;
        end else begin
          m_pend[s] = 1'b1;
        end
      end
      m_com = go;
    end
    for (int i = 0; i < 8; i++) e.o[i] = m_act[i];
    e.p   = m_pend;
    e.rdy = !m_com;
    e.ud  = m_com;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    z.rdy = 1'b1;
    @(negedge clk);
    wr_valid = 0;
    load_strobe = 0;
    rstn = 0;
    #1;
    chk_all(z);
    model_clear();
    q.delete();
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    logic a;
    logic hv;
    logic [2:0] hs;
    logic [15:0] hd;
    logic hm;
    int ud0;
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1;
    idle(2);
    do_reset();

    step(1, 3, 16'h1234, 0, 0, a);
    idle(5);
    step(0, 0, 0, 0, 1, a);
    idle(3);

    step(1, 7, 16'hFFFF, 1, 0, a);
    idle(1);
    ud0 = n_upd;
    step(0, 0, 0, 0, 1, a);
    idle(3);
    chk("no_upd_imm", 0, 16'(n_upd), 16'(ud0));

    step(1, 0, 16'h0010, 0, 1, a);
    idle(3);

    step(1, 1, 16'hAAAA, 0, 0, a);
    step(1, 1, 16'h5555, 0, 0, a);
    step(1, 6, 16'h0001, 0, 0, a);
    step(0, 0, 0, 0, 1, a);
    step(1, 2, 16'h0BAD, 0, 1, a);
    while (!a) step(1, 2, 16'h0BAD, 0, 0, a);
    idle(3);

    step(1, 5, 16'hBEEF, 0, 0, a);
    step(0, 0, 0, 0, 1, a);
    do_reset();
    step(1, 4, 16'h4444, 0, 0, a);
    step(0, 0, 0, 0, 1, a);
    idle(3);

    hv = 0; hs = 0; hd = 0; hm = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        hv = 0;
      end
      if (!hv) begin
        hv = ($urandom_range(0, 1) == 1);
        hs = 3'($urandom_range(0, 7));
        hd = 16'($urandom);
        hm = ($urandom_range(0, 3) == 0);
      end
      step(hv, hs, hd, hm, $urandom_range(0, 5) == 0, a);
      if (a) hv = 0;
    end
    idle(3);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
